// File: rtl/alu_unit.sv
// N-bit integer ALU with a combinational result and a registered shadow stage
// that holds the result and its status flags for pipelined consumers.
module alu_unit #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] r,
  output logic [N-1:0] r_q,
  output logic         zero_q,
  output logic         neg_q,
  output logic         carry_q,
  output logic         ovf_q
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_SLT = 3'd7
  } op_e;

  op_e          op;
  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic [SW-1:0] shamt;
  logic         carry;
  logic         ovf;

  assign op = op_e'(opcode);

  // ADD and SUB share one adder: SUB feeds ~b with a carry-in of 1.
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
  assign shamt  = b[SW-1:0];

  always_comb begin
    r     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        r     = sum[N-1:0];
        carry = sum[N];
        ovf   = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = a << shamt;
      OP_SHR: r = a >> shamt;
      OP_SLT: r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      r_q     <= r;
      zero_q  <= (r == '0);
      neg_q   <= r[N-1];
      carry_q <= carry;
      ovf_q   <= ovf;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed plan vectors, reset behaviour and
// randomized back-to-back traffic against an arithmetic reference model.
module tb_alu_unit;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic [2:0]   opcode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] r;
  logic [N-1:0] r_q;
  logic         zero_q;
  logic         neg_q;
  logic         carry_q;
  logic         ovf_q;

  int checks = 0;
  int errors = 0;

  alu_unit #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .a(a),
    .b(b),
    .r(r),
    .r_q(r_q),
    .zero_q(zero_q),
    .neg_q(neg_q),
    .carry_q(carry_q),
    .ovf_q(ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } vec_t;

  // Reference model built from integer arithmetic rather than bit slicing.
  function automatic void model(input logic [2:0] op, input logic [N-1:0] ia,
                                input logic [N-1:0] ib, output logic [N-1:0] er,
                                output logic ez, output logic en,
                                output logic ec, output logic ev);
    longint m, ua, ub, sa, sb, res, full, amt;
    m  = longint'(1) << N;
    ua = longint'(ia);
    ub = longint'(ib);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    amt = ub % (longint'(1) << $clog2(N));
    res = 0;
    ec = 1'b0;
    ev = 1'b0;
    case (op)
      3'd0: begin
        full = ua + ub;
        res  = full % m;
        ec   = (full >= m);
        ev   = ((sa + sb) > (m / 2 - 1)) || ((sa + sb) < -(m / 2));
      end
      3'd1: begin
        full = ua - ub;
        res  = (full + m) % m;
        ec   = (ua >= ub);
        ev   = ((sa - sb) > (m / 2 - 1)) || ((sa - sb) < -(m / 2));
      end
      3'd2: res = longint'(ia & ib);
      3'd3: res = longint'(ia | ib);
      3'd4: res = longint'(ia ^ ib);
      3'd5: res = (ua * (longint'(1) << amt)) % m;
      3'd6: res = ua / (longint'(1) << amt);
      default: res = (sa < sb) ? 1 : 0;
    endcase
    er = res[N-1:0];
    ez = (res == 0);
    en = (res >= m / 2);
  endfunction

  // Inputs change on the falling edge, away from the capturing edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [N-1:0] ia,
                               input logic [N-1:0] ib);
    @(negedge clk);
    opcode = op;
    a      = ia;
    b      = ib;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 3'd0;
    a      = 16'd40;
    b      = 16'd2;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (r_q !== 16'h0 || zero_q !== 1'b1 || neg_q !== 1'b0 ||
          carry_q !== 1'b0 || ovf_q !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold got r_q=%h z=%b n=%b c=%b v=%b want r_q=0000 z=1 n=0 c=0 v=0",
                 r_q, zero_q, neg_q, carry_q, ovf_q);
      end
      checks++;
      if (r !== 16'd42) begin
        errors++;
        $display("[TB] FAIL reset_comb_r got %h want %h", r, 16'd42);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (r_q !== 16'h0 || zero_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_early got r_q=%h z=%b want 0000 1", r_q, zero_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (r_q !== 16'd42 || zero_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_capture got r_q=%h z=%b want 002a 0", r_q, zero_q);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[$];
    vecs.push_back('{3'd0, 16'd40,   16'd2,    16'd42,   1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd1, 16'd40,   16'd2,    16'd38,   1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 16'd2,    16'd40,   16'hFFDA, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd3, 16'd40,   16'd31,   16'd63,   1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd2, 16'd40,   16'd31,   16'd8,    1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd4, 16'd40,   16'd31,   16'd55,   1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{3'd1, 16'd5,    16'd5,    16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd5, 16'd1,    16'h0013, 16'd8,    1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 16'h8000, 16'd15,   16'd1,    1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 16'hFFFF, 16'd1,    16'd1,    1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 16'd1,    16'hFFFF, 16'd0,    1'b1, 1'b0, 1'b0, 1'b0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      checks++;
      if (r !== vecs[i].r) begin
        errors++;
        $display("[TB] FAIL directed_r[%0d] op=%0d got %h want %h", i, vecs[i].op, r, vecs[i].r);
      end
      @(posedge clk);
      #1;
      checks++;
      if (r_q !== vecs[i].r || zero_q !== vecs[i].z || neg_q !== vecs[i].n ||
          carry_q !== vecs[i].c || ovf_q !== vecs[i].v) begin
        errors++;
        $display("[TB] FAIL directed_q[%0d] op=%0d got r_q=%h z=%b n=%b c=%b v=%b want %h %b %b %b %b",
                 i, vecs[i].op, r_q, zero_q, neg_q, carry_q, ovf_q,
                 vecs[i].r, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v);
      end
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(3'd0, 16'd40, 16'd2);
    @(posedge clk);
    #1;
    checks++;
    if (r_q !== 16'd42) begin
      errors++;
      $display("[TB] FAIL midreset_pre got r_q=%h want 002a", r_q);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (r_q !== 16'h0 || zero_q !== 1'b1 || r !== 16'd42) begin
      errors++;
      $display("[TB] FAIL midreset_async got r_q=%h z=%b r=%h want 0000 1 002a", r_q, zero_q, r);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (r_q !== 16'd42 || zero_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_recover got r_q=%h z=%b want 002a 0", r_q, zero_q);
    end
  endtask

  // Random traffic, new operands every cycle, with edge-case operands mixed in.
  task automatic test_back_to_back();
    logic [N-1:0] ta, tb_, er;
    logic [2:0]   op;
    logic         ez, en, ec, ev;
    for (int i = 0; i < 400; i++) begin
      op  = 3'($urandom_range(0, 7));
      ta  = N'($urandom);
      tb_ = N'($urandom);
      if ($urandom_range(0, 3) == 0) ta = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 3) == 0) tb_ = ($urandom_range(0, 1) != 0) ? 16'hFFFF : ta;
      model(op, ta, tb_, er, ez, en, ec, ev);
      applyStimulus(op, ta, tb_);
      #1;
      checks++;
      if (r !== er) begin
        errors++;
        $display("[TB] FAIL random_r[%0d] op=%0d a=%h b=%h got %h want %h", i, op, ta, tb_, r, er);
      end
      @(posedge clk);
      #1;
      checks++;
      if (r_q !== er || zero_q !== ez || neg_q !== en || carry_q !== ec || ovf_q !== ev) begin
        errors++;
        $display("[TB] FAIL random_q[%0d] op=%0d a=%h b=%h got %h %b%b%b%b want %h %b%b%b%b",
                 i, op, ta, tb_, r_q, zero_q, neg_q, carry_q, ovf_q, er, ez, en, ec, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
